// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM states, default latencies.
// Result bundle passed from the arithmetic core to the control unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  // hi/lo candidate plus write enable (cleared on divide by zero)
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_res_t;

  function automatic logic is_calc(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit product and signed/unsigned quotient/remainder.
// Ports: op, a, b in; res = {hi, lo, wr} out.
import mdu_pkg::*;

module mdu_calc (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res
);

  logic        sgn;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;
  logic [63:0] ea;
  logic [63:0] eb;
  logic [63:0] prod;

  always_comb begin
    sgn   = (op == MD_MULT) || (op == MD_DIV);
    ea    = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb    = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = ea * eb;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    abs_a = neg_a ? (32'd0 - a) : a;
    abs_b = neg_b ? (32'd0 - b) : b;
    // divide on magnitudes so 0x80000000 / -1 wraps cleanly;
    // a zero divisor is replaced since its result is never written
    dvs   = (b == 32'd0) ? 32'd1 : abs_b;
    uq    = abs_a / dvs;
    ur    = abs_a % dvs;
    q     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    r     = neg_a ? (32'd0 - ur) : ur;
    res   = '0;
    unique case (1'b1)
      (op == MD_MULT) || (op == MD_MULTU):
        res = '{hi: prod[63:32], lo: prod[31:0], wr: 1'b1};
      (op == MD_DIV) || (op == MD_DIVU):
        res = '{hi: r, lo: q, wr: (b != 32'd0)};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO and stall handshake.
// Ports: clk, rst(n, sync), start/op/a/b in; busy, hold, done, hi, lo out.
import mdu_pkg::*;

module mdu #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        hold,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  md_res_t     pend_q, pend_d;
  md_res_t     calc;

  mdu_calc u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .res (calc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pend_d  = '0;
          if (pend_q.wr) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: begin
        if (start) begin
          unique case (1'b1)
            (op == MD_MULT) || (op == MD_MULTU): begin
              state_d = ST_RUN;
              busy_d  = 1'b1;
              cnt_d   = CNT_W'(MUL_LAT);
              pend_d  = calc;
            end
            (op == MD_DIV) || (op == MD_DIVU): begin
              state_d = ST_RUN;
              busy_d  = 1'b1;
              cnt_d   = CNT_W'(DIV_LAT);
              pend_d  = calc;
            end
            (op == MD_MTHI): hi_d = a;
            (op == MD_MTLO): lo_d = a;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  // stall while computing and during the cycle a mult/div is issued
  assign hold = busy_q | (start & is_calc(op));
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
